// File: rtl/maze_pkg.sv
// Shared types for the depth-first maze solver: move codes, FSM states and move reversal.
package maze_pkg;

  typedef enum logic [1:0] {
    MV_N = 2'd0,
    MV_E = 2'd1,
    MV_S = 2'd2,
    MV_W = 2'd3
  } move_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_PROBE,
    ST_EVAL,
    ST_BACK,
    ST_DONE
  } state_t;

  // Opposite direction: N<->S, E<->W.
  function automatic move_t rev_move(input move_t m);
    return move_t'(m ^ 2'd2);
  endfunction

endpackage

// File: rtl/maze_dfs_solver_if.sv
// Maze memory port and path replay stream of the solver; master is the solver side.
interface maze_dfs_solver_if #(
    parameter int XW = 4,
    parameter int YW = 4
);
    import maze_pkg::*;

    logic [XW-1:0] mz_x;
    logic [YW-1:0] mz_y;
    logic          mz_rd;
    logic          mz_rdata;
    logic          mz_wr;
    logic          mz_wdata;
    logic          path_valid;
    logic          path_ready;
    move_t         path_move;
    logic          path_last;

    modport master (
        output mz_x, mz_y, mz_rd, mz_wr, mz_wdata,
        input  mz_rdata,
        output path_valid, path_move, path_last,
        input  path_ready
    );

    modport slave (
        input  mz_x, mz_y, mz_rd, mz_wr, mz_wdata,
        output mz_rdata,
        input  path_valid, path_move, path_last,
        output path_ready
    );
endinterface

// File: rtl/move_stack.sv
// LIFO of moves taken by the solver, with a second combinational read port for path replay.
module move_stack
    import maze_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           push,
    input  logic           pop,
    input  move_t          din,
    output move_t          top,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty,
    input  logic [SPW-1:0] rd_idx,
    output move_t          rd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    move_t          mem [DEPTH];
    logic [SPW-1:0] sp_q;
    logic [SPW-1:0] sp_m1;

    assign sp_m1 = sp_q - SPW'(1);
    assign sp    = sp_q;
    assign full  = (sp_q == SPW'(DEPTH));
    assign empty = (sp_q == '0);
    assign top   = mem[sp_m1[AW-1:0]];
    assign rd_data = (rd_idx < SPW'(DEPTH)) ? mem[rd_idx[AW-1:0]] : MV_N;

    // NOTE: storage has no reset; only sp is reset, and entries at or above sp are never read.
    always_ff @(posedge clk) begin
        if (push && !full) mem[sp_q[AW-1:0]] <= din;
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                sp_q <= '0;
        else if (clr)            sp_q <= '0;
        else if (push && !full)  sp_q <= sp_q + SPW'(1);
        else if (pop && !empty)  sp_q <= sp_m1;
    end

endmodule

// File: rtl/maze_dfs_solver.sv
// Depth-first maze solver from (0,0) to (COLS-1,ROWS-1) with backtracking and path replay.
// Optional MAZE_SOLVER_STATS_EN adds busy-cycle and backtrack counters.
module maze_dfs_solver
    import maze_pkg::*;
#(
    parameter int COLS  = 16,
    parameter int ROWS  = 16,
    parameter int DEPTH = 256,
    parameter int XW    = (COLS > 1) ? $clog2(COLS) : 1,
    parameter int YW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic          overflow,
    output logic [LW-1:0] path_len,
`ifdef MAZE_SOLVER_STATS_EN
    output logic [31:0]   stat_cycles,
    output logic [15:0]   stat_backs,
`endif
    maze_dfs_solver_if.master mz
);
    localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);
    localparam bit ORIGIN_IS_TARGET = (COLS == 1) && (ROWS == 1);

    state_t        state_q, state_d;
    logic [XW-1:0] px_q, px_d, nx, bx;
    logic [YW-1:0] py_q, py_d, ny, by;
    logic [2:0]    tr_q, tr_d;
    logic [LW-1:0] ri_q;
    logic          found_q, found_d, ovf_q, ovf_d;
    logic          oob, push, pop, clr, rd, wr;
    move_t         top, rd_data;
    logic [LW-1:0] sp;
    logic          full, empty, xfer;

    move_stack #(.DEPTH(DEPTH), .SPW(LW)) u_stack (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop),
        .din(move_t'(tr_q[1:0])), .top(top), .sp(sp), .full(full), .empty(empty),
        .rd_idx(ri_q), .rd_data(rd_data)
    );

    // Neighbour in the direction under trial, flagged when it would leave the maze.
    always_comb begin
        nx  = px_q;
        ny  = py_q;
        oob = 1'b0;
        case (move_t'(tr_q[1:0]))
            MV_N: begin oob = (py_q == '0);    ny = py_q - YW'(1); end
            MV_E: begin oob = (px_q == X_MAX); nx = px_q + XW'(1); end
            MV_S: begin oob = (py_q == Y_MAX); ny = py_q + YW'(1); end
            MV_W: begin oob = (px_q == '0);    nx = px_q - XW'(1); end
        endcase
    end

    always_comb begin
        bx = px_q;
        by = py_q;
        case (rev_move(top))
            MV_N: by = py_q - YW'(1);
            MV_E: bx = px_q + XW'(1);
            MV_S: by = py_q + YW'(1);
            MV_W: bx = px_q - XW'(1);
        endcase
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        tr_d    = tr_q;
        found_d = found_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_MARK;
                    px_d    = '0;
                    py_d    = '0;
                    tr_d    = '0;
                    found_d = 1'b0;
                    ovf_d   = 1'b0;
                    clr     = 1'b1;
                end
            end
            ST_MARK: begin
                wr = 1'b1;
                if (ORIGIN_IS_TARGET) begin
                    state_d = ST_DONE;
                    found_d = 1'b1;
                end else begin
                    state_d = ST_PROBE;
                    tr_d    = '0;
                end
            end
            ST_PROBE: begin
                if (tr_q == 3'd4) begin
                    state_d = ST_BACK;
                end else if (oob) begin
                    tr_d = tr_q + 3'd1;
                end else begin
                    rd      = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (mz.mz_rdata) begin
                    tr_d    = tr_q + 3'd1;
                    state_d = ST_PROBE;
                end else if (full) begin
                    state_d = ST_DONE;
                    ovf_d   = 1'b1;
                    found_d = 1'b0;
                end else begin
                    push = 1'b1;
                    wr   = 1'b1;
                    px_d = nx;
                    py_d = ny;
                    if (nx == X_MAX && ny == Y_MAX) begin
                        state_d = ST_DONE;
                        found_d = 1'b1;
                    end else begin
                        tr_d    = '0;
                        state_d = ST_PROBE;
                    end
                end
            end
            ST_BACK: begin
                if (empty) begin
                    state_d = ST_DONE;
                    found_d = 1'b0;
                end else begin
                    pop     = 1'b1;
                    px_d    = bx;
                    py_d    = by;
                    tr_d    = {1'b0, top} + 3'd1;
                    state_d = ST_PROBE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            px_q    <= '0;
            py_q    <= '0;
            tr_q    <= '0;
            found_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            tr_q    <= tr_d;
            found_q <= found_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      ri_q <= '0;
        else if (clr)  ri_q <= '0;
        else if (xfer) ri_q <= ri_q + LW'(1);
    end

    assign busy     = (state_q == ST_MARK) || (state_q == ST_PROBE) ||
                      (state_q == ST_EVAL) || (state_q == ST_BACK);
    assign done     = (state_q == ST_DONE);
    assign found    = found_q;
    assign overflow = ovf_q;
    assign path_len = done ? sp : '0;

    // The memory address follows the neighbour only while probing it or stepping into it.
    assign mz.mz_x     = (state_q == ST_PROBE || state_q == ST_EVAL) ? nx : px_q;
    assign mz.mz_y     = (state_q == ST_PROBE || state_q == ST_EVAL) ? ny : py_q;
    assign mz.mz_rd    = rd;
    assign mz.mz_wr    = wr;
    assign mz.mz_wdata = 1'b1;

    assign mz.path_valid = done && found_q && (ri_q < sp);
    assign mz.path_move  = mz.path_valid ? rd_data : MV_N;
    assign mz.path_last  = mz.path_valid && (ri_q == sp - LW'(1));
    assign xfer          = mz.path_valid && mz.path_ready;

`ifdef MAZE_SOLVER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_cycles <= '0;
            stat_backs  <= '0;
        end else if (clr) begin
            stat_cycles <= '0;
            stat_backs  <= '0;
        end else begin
            if (busy && stat_cycles != '1) stat_cycles <= stat_cycles + 32'd1;
            if (pop && stat_backs != '1)   stat_backs  <= stat_backs + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_maze_dfs_solver.sv
// Self-checking bench: 4x4, 4x4 with DEPTH=3 and 1x1 solvers against a queue-based DFS model.
module tb_maze_dfs_solver;
    import maze_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- 4x4 solver, deep stack ----------------
    logic       start4 = 1'b0, busy4, done4, found4, ovf4;
    logic [8:0] plen4;
    maze_dfs_solver_if #(.XW(2), .YW(2)) m4 ();
`ifdef MAZE_SOLVER_STATS_EN
    logic [31:0] sc4, sco, sc1;
    logic [15:0] sb4, sbo, sb1;
`endif
    maze_dfs_solver #(.COLS(4), .ROWS(4), .DEPTH(256)) u4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
        .found(found4), .overflow(ovf4), .path_len(plen4),
`ifdef MAZE_SOLVER_STATS_EN
        .stat_cycles(sc4), .stat_backs(sb4),
`endif
        .mz(m4)
    );

    logic [15:0] walls4 = '0, vis4 = '0;
    logic        clr4 = 1'b0;
    int          collide = 0;
    always @(posedge clk) begin
        if (clr4) vis4 <= '0;
        else if (m4.mz_wr) vis4[{m4.mz_y, m4.mz_x}] <= 1'b1;
        m4.mz_rdata <= m4.mz_rd & (walls4[{m4.mz_y, m4.mz_x}] | vis4[{m4.mz_y, m4.mz_x}]);
        if (m4.mz_rd && m4.mz_wr) collide <= collide + 1;
    end

    // ---------------- 4x4 solver, DEPTH=3 ----------------
    logic       starto = 1'b0, busyo, doneo, foundo, ovfo;
    logic [1:0] pleno;
    maze_dfs_solver_if #(.XW(2), .YW(2)) mo ();
    maze_dfs_solver #(.COLS(4), .ROWS(4), .DEPTH(3)) uo (
        .clk(clk), .rst(rst), .start(starto), .busy(busyo), .done(doneo),
        .found(foundo), .overflow(ovfo), .path_len(pleno),
`ifdef MAZE_SOLVER_STATS_EN
        .stat_cycles(sco), .stat_backs(sbo),
`endif
        .mz(mo)
    );
    logic [15:0] viso = '0;
    logic        clro = 1'b0;
    always @(posedge clk) begin
        if (clro) viso <= '0;
        else if (mo.mz_wr) viso[{mo.mz_y, mo.mz_x}] <= 1'b1;
        mo.mz_rdata <= mo.mz_rd & viso[{mo.mz_y, mo.mz_x}];
    end

    // ---------------- 1x1 solver ----------------
    logic       start1 = 1'b0, busy1, done1, found1, ovf1;
    logic [8:0] plen1;
    maze_dfs_solver_if #(.XW(1), .YW(1)) m1 ();
    maze_dfs_solver #(.COLS(1), .ROWS(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .found(found1), .overflow(ovf1), .path_len(plen1),
`ifdef MAZE_SOLVER_STATS_EN
        .stat_cycles(sc1), .stat_backs(sb1),
`endif
        .mz(m1)
    );

    // ---------------- reference DFS on a 4x4 grid ----------------
    bit exp_found, exp_ov;
    int exp_backs;
    int exp_mv[$];

    task automatic model(input logic [15:0] w, input int depth);
        bit vis[16];
        int dx[4] = '{0, 1, 0, -1};
        int dy[4] = '{-1, 0, 1, 0};
        int x = 0, y = 0, t = 0, nx, ny, m;
        for (int i = 0; i < 16; i++) vis[i] = w[i];
        vis[0] = 1'b1;
        exp_found = 1'b0; exp_ov = 1'b0; exp_backs = 0;
        exp_mv.delete();
        forever begin
            if (t == 4) begin
                if (exp_mv.size() == 0) break;
                m = exp_mv.pop_back();
                exp_backs++;
                x -= dx[m]; y -= dy[m]; t = m + 1;
            end else begin
                nx = x + dx[t]; ny = y + dy[t];
                if (nx < 0 || nx > 3 || ny < 0 || ny > 3 || vis[ny*4+nx]) t++;
                else if (exp_mv.size() == depth) begin exp_ov = 1'b1; break; end
                else begin
                    exp_mv.push_back(t);
                    x = nx; y = ny; vis[y*4+x] = 1'b1;
                    if (x == 3 && y == 3) begin exp_found = 1'b1; break; end
                    t = 0;
                end
            end
        end
    endtask

    task automatic replay4(input string tag, input int take);
        int got = 0, cyc = 0, x = 0, y = 0, hit = 0, mv;
        int n = exp_mv.size();
        bit r;
        while (got < take && cyc < 400) begin
            check({tag, "_pvalid"}, m4.path_valid, 1);
            check({tag, "_pmove"}, m4.path_move, exp_mv[got]);
            check({tag, "_plast"}, m4.path_last, got == n - 1);
            mv = int'(m4.path_move);
            r  = 1'($urandom_range(0, 1));
            m4.path_ready = r;
            @(posedge clk); #1;
            cyc++;
            if (r) begin
                got++;
                case (mv)
                    0: y--;
                    1: x++;
                    2: y++;
                    default: x--;
                endcase
                if (x < 0 || x > 3 || y < 0 || y > 3) hit++;
                else if (walls4[y*4+x]) hit++;
            end
        end
        m4.path_ready = 1'b0;
        check({tag, "_replay_count"}, got, take);
        if (take == n) begin
            check({tag, "_pvalid_end"}, m4.path_valid, 0);
            check({tag, "_rewalk_end"}, {x[7:0], y[7:0]}, 16'h0303);
            check({tag, "_rewalk_wall"}, hit, 0);
        end
    endtask

    int last_cnt;

    task automatic run4(input string tag, input logic [15:0] w, input int take, input bit poke);
        int cnt = 0;
        walls4 = w;
        model(w, 256);
        clr4 = 1'b1; @(posedge clk); #1; clr4 = 1'b0;
        start4 = 1'b1; @(posedge clk); #1; start4 = 1'b0;
        check({tag, "_mark"}, {done4, busy4}, 2'b01);
        while (!done4 && cnt < 2000) begin
            start4 = poke && (cnt == 3);
            @(posedge clk); #1;
            cnt++;
        end
        start4 = 1'b0;
        last_cnt = cnt;
        check({tag, "_done"}, {done4, busy4}, 2'b10);
        check({tag, "_found"}, found4, exp_found);
        check({tag, "_overflow"}, ovf4, exp_ov);
        check({tag, "_path_len"}, plen4, exp_mv.size());
`ifdef MAZE_SOLVER_STATS_EN
        check({tag, "_stat_cycles"}, sc4, cnt);
        check({tag, "_stat_backs"}, sb4, exp_backs);
`endif
        if (exp_found) replay4(tag, (take < 0) ? exp_mv.size() : take);
        else begin
            m4.path_ready = 1'b1;
            repeat (3) begin
                check({tag, "_pvalid_never"}, m4.path_valid, 0);
                @(posedge clk); #1;
            end
            m4.path_ready = 1'b0;
        end
    endtask

    initial begin
        int cnt;
        logic [15:0] w;
        rst = 1'b0;
        m4.path_ready = 1'b0;
        mo.path_ready = 1'b1;
        m1.path_ready = 1'b1;
        m1.mz_rdata   = 1'b0;
        #12;
        check("reset_outputs", {busy4, done4, found4, ovf4, plen4, m4.mz_rd, m4.mz_wr,
              m4.path_valid, m4.path_last, m4.path_move, m4.mz_x, m4.mz_y}, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        run4("open", 16'h0000, -1, 1'b0);
        check("open_latency", last_cnt <= 30, 1);
        run4("snake_part", 16'h70E8, 2, 1'b0);
        run4("snake", 16'h70E8, -1, 1'b0);
`ifdef MAZE_SOLVER_STATS_EN
        check("snake_backs_nonzero", sb4 > 0, 1);
`endif
        run4("walled", 16'h4800, -1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            w = 16'($urandom & $urandom) & 16'hFFFE;
            run4($sformatf("rand%0d", i), w, -1, i[0]);
        end

        // Reset pulsed mid-search must clear every output without waiting for a clock edge.
        walls4 = '0;
        clr4 = 1'b1; @(posedge clk); #1; clr4 = 1'b0;
        start4 = 1'b1; @(posedge clk); #1; start4 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", busy4, 1);
        rst = 1'b0;
        #1;
        check("async_reset", {busy4, done4, found4, ovf4, plen4, m4.mz_rd, m4.mz_wr,
              m4.path_valid, m4.path_last, m4.path_move, m4.mz_x, m4.mz_y}, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run4("after_reset", 16'h0000, -1, 1'b0);

        // DEPTH=3 on an open maze runs out of stack on the fourth push.
        model(16'h0000, 3);
        clro = 1'b1; @(posedge clk); #1; clro = 1'b0;
        starto = 1'b1; @(posedge clk); #1; starto = 1'b0;
        cnt = 0;
        while (!doneo && cnt < 500) begin @(posedge clk); #1; cnt++; end
        check("ovf_done", doneo, 1);
        check("ovf_flag", ovfo, exp_ov);
        check("ovf_found", foundo, exp_found);
        check("ovf_path_len", pleno, exp_mv.size());
        check("ovf_pvalid", mo.path_valid, 0);

        // 1x1: origin is the target.
        start1 = 1'b1; @(posedge clk); #1; start1 = 1'b0;
        check("one_mark", {busy1, done1}, 2'b10);
        @(posedge clk); #1;
        check("one_done", {busy1, done1, found1, ovf1}, 4'b0110);
        check("one_path_len", plen1, 0);
        check("one_pvalid", m1.path_valid, 0);

        check("rd_wr_exclusive", collide, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/maze_dfs_solver.md
# maze_dfs_solver

Parametrised depth-first maze solver: searches from cell (0,0) to cell (COLS-1,ROWS-1) over an external 1-bit-per-cell maze memory, backtracking through an internal move stack. It is the next-generation replacement for the fixed 16x16 maze datapath-plus-controller pair and adds:
- generic dimensions and stack depth;
- overflow detection;
- a valid/ready path replay port that streams the solution from start to target, with no second reversal stack.

## Interface
Parameters:
- COLS, 16, maze width in cells (>=1)
- ROWS, 16, maze height in cells (>=1)
- DEPTH, 256, move stack entries
- XW, $clog2(COLS) (min 1), x coordinate width
- YW, $clog2(ROWS) (min 1), y coordinate width
- LW, $clog2(DEPTH+1), path length width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; accepted only in IDLE or DONE
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  level; high in DONE until the next accepted start
- found  out  1  valid while done; 1 means target reached
- overflow  out  1  valid while done; 1 means the search aborted on a full stack
- path_len  out  LW  stack depth at DONE
- mz_x  out  XW  maze memory column
- mz_y  out  YW  maze memory row
- mz_rd  out  1  read strobe; mz_rdata is valid on the next cycle
- mz_rdata  in  1  1 = wall or visited, 0 = free
- mz_wr  out  1  write strobe; writes mz_wdata at (mz_x,mz_y)
- mz_wdata  out  1  always 1 (visited mark)
- path_valid  out  1  replay move available
- path_ready  in  1  consumer accepts the move
- path_move  out  2  move code
- path_last  out  1  final move of the path

## Operation
- Move codes:
  - 0 N: y-1
  - 1 E: x+1
  - 2 S: y+1
  - 3 W: x-1
  - Reverse of m is m^2.
- Internal state: position (px,py), 3-bit try counter, stack pointer sp, replay index ri.
- FSM states:
  - IDLE: waits for start.
  - MARK:
    - mz_wr at (0,0).
    - If start equals target, go to DONE with found=1 and path_len=0.
    - Otherwise go to PROBE with try=0.
  - PROBE:
    - try==4: go to BACK.
    - Neighbour out of bounds: try++ and stay in PROBE, with no memory access.
    - Otherwise: mz_rd at the neighbour, go to EVAL.
  - EVAL:
    - rdata=1: try++ and go to PROBE.
    - rdata=0 and sp==DEPTH: go to DONE with overflow=1, found=0.
    - rdata=0 otherwise:
      - push try; move to the neighbour; mz_wr at the neighbour, same cycle.
      - Neighbour is the target: go to DONE with found=1.
      - Otherwise: try=0 and go to PROBE.
  - BACK:
    - sp==0: go to DONE with found=0.
    - Otherwise:
      - pop m and step by reverse(m);
      - try=m+1 and go to PROBE.
  - DONE: done=1; replay is active if found.
- Replay:
  - path_move = stack[ri], with ri starting at 0.
  - path_valid = found && ri<path_len.
  - path_last = (ri==path_len-1).
  - On a valid&ready transfer, ri++.
  - path_len=0 means path_valid is never asserted.
- Cell marking: visited cells stay marked; the solver never clears memory. Clearing the maze between runs is the memory owner's responsibility.

## Timing
- Reset (rst low, asynchronous):
  - state IDLE;
  - all outputs 0;
  - px=py=0, sp=0, ri=0.
- start is sampled at a clk edge:
  - the following cycle is MARK;
  - busy=1 from MARK onward;
  - done drops in the same cycle busy rises.
- Start while busy is ignored.
- Start in DONE abandons any unfinished replay: ri and sp return to 0.
- Per-step cost:
  - out-of-bounds skip: 1 cycle;
  - probe: 2 cycles (PROBE+EVAL);
  - backtrack: 1 cycle (BACK) plus re-probe.
- mz_rd and mz_wr are never asserted in the same cycle. mz_x and mz_y are don't-care when both strobes are low.
- Push and pop never occur in the same cycle.
- Replay: path_move and path_last are stable while path_valid && !path_ready. Throughput is one move per cycle.
- Reset asserted mid-search or mid-replay aborts immediately; no memory write completes in that cycle.

## Configuration
- MAZE_SOLVER_STATS_EN defined:
  - adds outputs stat_cycles (32 bit) and stat_backs (16 bit), both cleared by reset and by an accepted start;
  - stat_cycles counts busy cycles;
  - stat_backs counts BACK entries that pop;
  - both saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package maze_pkg:
  - move_t (2-bit) with MV_N/MV_E/MV_S/MV_W;
  - rev_move() function;
  - state_t enum for IDLE/MARK/PROBE/EVAL/BACK/DONE.
- Sub-module move_stack #(DEPTH):
  - LIFO of move_t with push, pop, top, sp, full and empty;
  - an extra combinational indexed read port used by replay;
  - asynchronous active-low reset clears sp.
- Neighbour and bounds logic stays inline in the solver.

## Test plan
- Open 4x4 maze (all 0), then start:
  - found=1, path_len=6;
  - replay E,E,E,S,S,S with path_last on the 6th move;
  - done within 30 cycles.
- 4x4 maze whose only route is a snake (walls forcing dead ends):
  - stat_backs>0;
  - replayed path, re-walked on the model, reaches (3,3) with no wall cell.
- Target walled off in 4x4: found=0, overflow=0, path_len=0, path_valid never 1.
- DEPTH=3 on an open 4x4 maze: overflow=1, found=0 on the 4th push attempt.
- COLS=ROWS=1: DONE two cycles after start, with found=1 and path_len=0.
- Replay with path_ready toggled randomly, and rst pulsed low mid-search on a second run:
  - path_move stays stable while stalled;
  - reset returns all outputs to 0 asynchronously.
